// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction bus and the data bus.
// Transactions are serialized through an IDLE/ADDR/DATA FSM working from latched request copies.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state_r;
  state_t              state_next_s;
  logic                owner_r;
  logic                last_grant_r;
  logic                grant_valid_s;
  logic                grant_d_s;
  logic                addr_ok_s;
  logic                data_ok_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          size_r;
  logic [7:0]          strobe_r;
  logic [DATA_W-1:0]   data_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and grant decision; contention goes to whoever did not win last time
  always_comb begin
    state_next_s  = state_r;
    grant_valid_s = 1'b0;
    grant_d_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ireq_valid && dreq_valid) begin
          grant_valid_s = 1'b1;
          grant_d_s     = (last_grant_r == OWN_I);
        end else if (ireq_valid) begin
          grant_valid_s = 1'b1;
          grant_d_s     = 1'b0;
        end else if (dreq_valid) begin
          grant_valid_s = 1'b1;
          grant_d_s     = 1'b1;
        end else begin
          grant_valid_s = 1'b0;
        end
        if (grant_valid_s) begin
          state_next_s = ST_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (mresp_addr_ok && mresp_data_ok) begin
          state_next_s = ST_IDLE;
        end else if (mresp_addr_ok) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (mresp_data_ok) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Capture the winner so later changes on the requester side have no effect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r      <= OWN_I;
      last_grant_r <= OWN_I;
      addr_r       <= {ADDR_W{1'b0}};
      size_r       <= 3'b000;
      strobe_r     <= 8'h00;
      data_r       <= {DATA_W{1'b0}};
    end else if (grant_valid_s) begin
      owner_r      <= grant_d_s;
      last_grant_r <= grant_d_s;
      if (grant_d_s) begin
        addr_r   <= dreq_addr;
        size_r   <= dreq_size;
        strobe_r <= dreq_strobe;
        data_r   <= dreq_data;
      end else begin
        addr_r   <= ireq_addr;
        size_r   <= 3'b010;
        strobe_r <= 8'h00;
        data_r   <= {DATA_W{1'b0}};
      end
    end else begin
      owner_r      <= owner_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Outputs: memory side from latches, responses steered combinationally to the owner
  always_comb begin
    mreq_valid = 1'b0;
    addr_ok_s  = 1'b0;
    data_ok_s  = 1'b0;
    case (state_r)
      ST_ADDR: begin
        mreq_valid = 1'b1;
        addr_ok_s  = mresp_addr_ok;
        data_ok_s  = mresp_addr_ok & mresp_data_ok;
      end
      ST_DATA: begin
        data_ok_s  = mresp_data_ok;
      end
      default: begin
        mreq_valid = 1'b0;
      end
    endcase
    mreq_addr     = addr_r;
    mreq_size     = size_r;
    mreq_strobe   = strobe_r;
    mreq_data     = data_r;
    iresp_addr_ok = addr_ok_s & (owner_r == OWN_I);
    iresp_data_ok = data_ok_s & (owner_r == OWN_I);
    dresp_addr_ok = addr_ok_s & (owner_r == OWN_D);
    dresp_data_ok = data_ok_s & (owner_r == OWN_D);
    if (iresp_data_ok) begin
      if (addr_r[2]) begin
        iresp_data = mresp_data[DATA_W-1 -: 32];
      end else begin
        iresp_data = mresp_data[31:0];
      end
    end else begin
      iresp_data = 32'h0000_0000;
    end
    if (dresp_data_ok) begin
      dresp_data = mresp_data;
    end else begin
      dresp_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the bench plays both the core and the memory.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_addr_ok, mresp_data_ok;
  logic [63:0] mresp_data;

  int n_cmp = 0;
  int n_err = 0;

  wire [239:0] all_out = {mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
                          iresp_addr_ok, iresp_data_ok, iresp_data,
                          dresp_addr_ok, dresp_data_ok, dresp_data};

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; stimulus goes here, checks one unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'b000;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0; mresp_data = 64'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    n_cmp++;
    if (all_out !== 240'h0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    step();
    step();
    n_cmp++;
    if (all_out !== 240'h0) begin
      n_err++; $display("FAIL reset_hold got=%h want=0", all_out);
    end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_ibus_only();
    logic [31:0] exp_words [2];
    logic [63:0] addrs [2];
    addrs[0] = 64'h8000_0004; exp_words[0] = 32'h1111_2222;
    addrs[1] = 64'h8000_0008; exp_words[1] = 32'h3333_4444;
    for (int k = 0; k < 2; k++) begin
      ireq_valid = 1'b1; ireq_addr = addrs[k];
      step();
      mresp_addr_ok = 1'b1; mresp_data_ok = 1'b1; mresp_data = 64'h1111_2222_3333_4444;
      #1;
      n_cmp++;
      if ({mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data} !== {1'b1, addrs[k], 3'b010, 8'h00, 64'h0}) begin
        n_err++; $display("FAIL ibus_mreq got=%b %h %b %h %h", mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data);
      end
      n_cmp++;
      if ({iresp_addr_ok, iresp_data_ok, iresp_data} !== {1'b1, 1'b1, exp_words[k]}) begin
        n_err++; $display("FAIL ibus_resp got=%b %b %h want=1 1 %h", iresp_addr_ok, iresp_data_ok, iresp_data, exp_words[k]);
      end
      n_cmp++;
      if ({dresp_addr_ok, dresp_data_ok, dresp_data} !== 66'h0) begin
        n_err++; $display("FAIL ibus_dresp_quiet got=%b %b %h want=0", dresp_addr_ok, dresp_data_ok, dresp_data);
      end
      step();
      clear_inputs();
      #1;
      n_cmp++;
      if ({mreq_valid, iresp_data_ok, iresp_data} !== 34'h0) begin
        n_err++; $display("FAIL ibus_bubble got=%b %b %h want=0", mreq_valid, iresp_data_ok, iresp_data);
      end
    end
  endtask

  task automatic test_dbus_store();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'b011;
    dreq_strobe = 8'hFF; dreq_data = 64'h0000_0000_DEAD_BEEF;
    step();
    mresp_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data} !== {1'b1, 64'h8000_1000, 3'b011, 8'hFF, 64'h0000_0000_DEAD_BEEF}) begin
      n_err++; $display("FAIL dbus_mreq got=%b %h %b %h %h", mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data);
    end
    n_cmp++;
    if ({dresp_addr_ok, dresp_data_ok, iresp_addr_ok} !== 3'b100) begin
      n_err++; $display("FAIL dbus_addr_ok got=%b%b%b want=100", dresp_addr_ok, dresp_data_ok, iresp_addr_ok);
    end
    step();
    mresp_addr_ok = 1'b0;
    #1;
    n_cmp++;
    if ({mreq_valid, dresp_data_ok, dresp_addr_ok} !== 3'b000) begin
      n_err++; $display("FAIL dbus_wait1 got=%b%b%b want=000", mreq_valid, dresp_data_ok, dresp_addr_ok);
    end
    step();
    mresp_data_ok = 1'b1; mresp_data = 64'h0123_4567_89AB_CDEF;
    #1;
    n_cmp++;
    if ({mreq_valid, dresp_data_ok, dresp_data} !== {1'b0, 1'b1, 64'h0123_4567_89AB_CDEF}) begin
      n_err++; $display("FAIL dbus_data_ok got=%b %b %h", mreq_valid, dresp_data_ok, dresp_data);
    end
    n_cmp++;
    if ({iresp_addr_ok, iresp_data_ok, iresp_data} !== 34'h0) begin
      n_err++; $display("FAIL dbus_iresp_quiet got=%b %b %h want=0", iresp_addr_ok, iresp_data_ok, iresp_data);
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if ({mreq_valid, dresp_data_ok, dresp_data} !== 66'h0) begin
      n_err++; $display("FAIL dbus_after got=%b %b %h want=0", mreq_valid, dresp_data_ok, dresp_data);
    end
  endtask

  task automatic test_contention();
    logic exp_d [4];
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_2000;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_3008; dreq_size = 3'b011;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      mresp_addr_ok = 1'b1; mresp_data_ok = 1'b1; mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
      #1;
      n_cmp++;
      if (mreq_addr !== (exp_d[k] ? 64'h8000_3008 : 64'h8000_2000)) begin
        n_err++; $display("FAIL contend_grant%0d got=%h want_d=%b", k, mreq_addr, exp_d[k]);
      end
      n_cmp++;
      if ({mreq_valid, dresp_data_ok, iresp_data_ok} !== {1'b1, exp_d[k], ~exp_d[k]}) begin
        n_err++; $display("FAIL contend_resp%0d got=%b%b%b want_d=%b", k, mreq_valid, dresp_data_ok, iresp_data_ok, exp_d[k]);
      end
      step();
      mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0; mresp_data = 64'h0;
      #1;
      n_cmp++;
      if (mreq_valid !== 1'b0) begin
        n_err++; $display("FAIL contend_bubble%0d got=%b want=0", k, mreq_valid);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_held_change();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_4000; dreq_size = 3'b010;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    step();
    mresp_addr_ok = 1'b1;
    step();
    mresp_addr_ok = 1'b1;
    dreq_addr = 64'h9999_0000;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_5000;
    #1;
    n_cmp++;
    if ({mreq_valid, mreq_addr} !== {1'b0, 64'h8000_4000}) begin
      n_err++; $display("FAIL held_addr got=%b %h want=0 8000_4000", mreq_valid, mreq_addr);
    end
    n_cmp++;
    if ({dresp_addr_ok, iresp_addr_ok} !== 2'b00) begin
      n_err++; $display("FAIL held_addr_ok_in_data got=%b%b want=00", dresp_addr_ok, iresp_addr_ok);
    end
    step();
    mresp_addr_ok = 1'b0; mresp_data_ok = 1'b1; mresp_data = 64'h5555_6666_7777_8888;
    #1;
    n_cmp++;
    if ({dresp_data_ok, iresp_data_ok, dresp_data, mreq_addr} !== {1'b1, 1'b0, 64'h5555_6666_7777_8888, 64'h8000_4000}) begin
      n_err++; $display("FAIL held_resp got=%b %b %h %h", dresp_data_ok, iresp_data_ok, dresp_data, mreq_addr);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_6000; dreq_size = 3'b011;
    dreq_strobe = 8'h0F; dreq_data = 64'h1234;
    step();
    mresp_addr_ok = 1'b1;
    step();
    mresp_addr_ok = 1'b0; mresp_data_ok = 1'b1; mresp_data = 64'hFFFF_0000_FFFF_0000;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== 240'h0) begin
      n_err++; $display("FAIL reset_mid_outputs got=%h want=0", all_out);
    end
    step();
    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_7000;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_8000; dreq_strobe = 8'h00;
    #1;
    n_cmp++;
    if ({dresp_data_ok, iresp_data_ok, mreq_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_mid_stale got=%b%b%b want=000", dresp_data_ok, iresp_data_ok, mreq_valid);
    end
    step();
    mresp_data_ok = 1'b0; mresp_data = 64'h0;
    #1;
    n_cmp++;
    if ({mreq_valid, mreq_addr} !== {1'b1, 64'h8000_8000}) begin
      n_err++; $display("FAIL reset_mid_first_grant got=%b %h want=1 8000_8000", mreq_valid, mreq_addr);
    end
    mresp_addr_ok = 1'b1; mresp_data_ok = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_spurious();
    mresp_data_ok = 1'b1; mresp_addr_ok = 1'b1; mresp_data = 64'hCAFE_F00D_CAFE_F00D;
    #1;
    n_cmp++;
    if ({iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data, mreq_valid} !== 101'h0) begin
      n_err++; $display("FAIL spurious_idle got=%b%b %h %b%b %h %b", iresp_addr_ok, iresp_data_ok, iresp_data,
                        dresp_addr_ok, dresp_data_ok, dresp_data, mreq_valid);
    end
    step();
    #1;
    n_cmp++;
    if ({mreq_valid, iresp_data_ok, dresp_data_ok} !== 3'b000) begin
      n_err++; $display("FAIL spurious_stays_idle got=%b%b%b want=000", mreq_valid, iresp_data_ok, dresp_data_ok);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ibus_only();
    test_dbus_store();
    test_reset();
    test_contention();
    test_held_change();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory port between the core's instruction bus (fetch) and data bus (memory stage). It sits between `core` and the memory interconnect. Each transaction is serialized through a small FSM, and bus ownership is granted round-robin. The core stalls fetch and the whole pipeline on outstanding bus requests, so the arbiter must never reorder, merge or drop a transaction.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: memory data width; ibus data is fixed at 32.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `ireq_valid`, in, 1: fetch request; held with `ireq_addr` until `iresp_data_ok`.
- `ireq_addr`, in, ADDR_W: fetch address, 4-byte aligned.
- `iresp_addr_ok`, out, 1: ibus address accepted by memory.
- `iresp_data_ok`, out, 1: ibus data valid, one-cycle pulse.
- `iresp_data`, out, 32: instruction word.
- `dreq_valid`, in, 1: load/store request; held with its fields until `dresp_data_ok`.
- `dreq_addr`, in, ADDR_W: data address.
- `dreq_size`, in, 3: access size.
- `dreq_strobe`, in, 8: byte write enables; 0 means read.
- `dreq_data`, in, DATA_W: store data.
- `dresp_addr_ok`, out, 1: dbus address accepted by memory.
- `dresp_data_ok`, out, 1: dbus data valid, one-cycle pulse.
- `dresp_data`, out, DATA_W: load data.
- `mreq_valid`, out, 1: memory request.
- `mreq_addr`, out, ADDR_W: memory address.
- `mreq_size`, out, 3: memory access size.
- `mreq_strobe`, out, 8: memory byte write enables.
- `mreq_data`, out, DATA_W: memory write data.
- `mresp_addr_ok`, in, 1: memory accepted the address phase.
- `mresp_data_ok`, in, 1: memory completed the transaction.
- `mresp_data`, in, DATA_W: memory read data.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `owner` (I/D), `last_grant` (I/D), and latched copies of the winning request's addr/size/strobe/data.
- IDLE:
  - Only ireq pending: grant I.
  - Only dreq pending: grant D.
  - Both pending: grant the requester that is not `last_grant`.
  - On a grant: latch the request fields, set `owner` and `last_grant`, go to ADDR.
- ADDR:
  - Drive `mreq_valid`=1 from the latched fields.
  - For an ibus grant, drive size=3'b010 and strobe=0; data is don't-care and driven as 0.
  - On `mresp_addr_ok`, pulse the owner's `*_addr_ok`.
  - If `mresp_data_ok` is asserted in the same cycle, complete immediately and go to IDLE; otherwise go to DATA.
- DATA:
  - `mreq_valid`=0.
  - On `mresp_data_ok`, pulse the owner's `*_data_ok` with data passed through combinationally, then go to IDLE.
- `iresp_data` = `mresp_data[63:32]` if the latched `addr[2]`=1, else `mresp_data[31:0]`.
- `dresp_data` = `mresp_data` unchanged.
- Response data outputs are 0 whenever the corresponding `data_ok` is 0.
- The non-owner's `addr_ok` and `data_ok` are always 0.
- Requester inputs are ignored outside IDLE. Changes to a held request mid-transaction have no effect, because the latched copy is used.
- Fairness: with both requesters continuously pending, grants strictly alternate. The worst-case wait is one foreign transaction.
- Reset (asynchronous, any state):
  - State → IDLE, `owner`=I, `last_grant`=I, so the first contended grant goes to D.
  - Latches → 0.
  - Any in-flight transaction is abandoned with no response pulse.

## Timing
- Reset values: every output is 0.
- Grant decision in cycle N (IDLE, request visible) → `mreq_valid`=1 in cycle N+1.
- Minimum latency from request to `*_data_ok` is 1 cycle, with memory asserting addr_ok and data_ok together in N+1.
- `*_addr_ok` and `*_data_ok` are combinational from `mresp_*` in the owning state; each lasts exactly one cycle.
- After `data_ok` in cycle M, the FSM is in IDLE in M+1 and can issue the next `mreq_valid` in M+2. There is one bubble per transaction.
- `mresp_data_ok` while in IDLE is ignored.
- `mresp_addr_ok` while in DATA is ignored.

## Test plan
- ibus only: `ireq_addr`=0x8000_0004, memory returns 0x1111_2222_3333_4444 with addr_ok+data_ok in the first ADDR cycle → `iresp_data`=0x1111_2222 one cycle after the request; `dresp_*`=0.
- dbus store only: addr 0x8000_1000, strobe 0xFF, data 0xDEAD_BEEF, memory addr_ok at +1 and data_ok at +3 → `mreq_valid` high for exactly one cycle, `mreq_strobe`=0xFF, `dresp_data_ok` pulses once at +3.
- Contention after reset: ireq and dreq asserted together → D granted first, then I. With both held pending, grants follow D, I, D, I.
- Held-request change: alter `dreq_addr` while in DATA → `mreq_addr` keeps the latched value; the response goes only to D.
- Reset mid-transaction: assert `reset`=0 in DATA → all outputs 0 immediately. After release, the next contended grant goes to D, and no stale `data_ok` appears.
- Spurious memory response: `mresp_data_ok`=1 in IDLE → no response pulse on either bus.
